// File: rtl/alu_prog_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_prog_sequencer
//  Purpose  : Programmable replay sequencer for a register-file / ALU
//             datapath. A DEPTH-entry table of control words is loaded via
//             prog_we/prog_addr/prog_data. It is then replayed one entry per
//             clock after start. hold stalls the current entry.
//  Ports    : clk, rst (async, active-high)
//             prog_we, prog_addr, prog_data  - program table write port
//             start, hold                    - run control
//             loop_cnt (ALU_SEQ_LOOP_EN)     - extra passes per run
//             reg_we, FlagEn, RorI, opcode,
//             Rsrc, Rdest, imm               - decoded datapath controls
//             pc, busy, done                 - status
//  Options  : `define ALU_SEQ_LOOP_EN to add the loop_cnt repeat feature.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_prog_sequencer #(
  parameter int DEPTH = 16,
  parameter int NREG  = 16,
  parameter int OPW   = 8,
  parameter int IMMW  = 8,
  localparam int PCW     = $clog2(DEPTH),
  localparam int RW      = $clog2(NREG),
  localparam int ENTRY_W = 4 + OPW + 3*RW + IMMW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [PCW-1:0]     prog_addr,
  input  logic [ENTRY_W-1:0] prog_data,
  input  logic               start,
  input  logic               hold,
`ifdef ALU_SEQ_LOOP_EN
  input  logic [7:0]         loop_cnt,
`endif
  output logic [NREG-1:0]    reg_we,
  output logic               FlagEn,
  output logic               RorI,
  output logic [OPW-1:0]     opcode,
  output logic [RW-1:0]      Rsrc,
  output logic [RW-1:0]      Rdest,
  output logic [IMMW-1:0]    imm,
  output logic [PCW-1:0]     pc,
  output logic               busy,
  output logic               done
);

  // Entry field positions, LSB upwards.
  localparam int C_RDEST_LSB = IMMW;
  localparam int C_RSRC_LSB  = C_RDEST_LSB + RW;
  localparam int C_OP_LSB    = C_RSRC_LSB + RW;
  localparam int C_RORI_BIT  = C_OP_LSB + OPW;
  localparam int C_FLAG_BIT  = C_RORI_BIT + 1;
  localparam int C_WREG_LSB  = C_FLAG_BIT + 1;
  localparam int C_WREN_BIT  = C_WREG_LSB + RW;
  localparam int C_LAST_BIT  = C_WREN_BIT + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PCW-1:0]       r_pc;
  logic [PCW-1:0]       w_pc_nxt;
  logic [ENTRY_W-1:0]   r_table [DEPTH];
  logic [ENTRY_W-1:0]   w_entry;
  logic [RW-1:0]        w_wreg;
  logic [NREG-1:0]      w_onehot;
  logic                 w_retire_last;
  logic                 w_rewind;

  // Program table: no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && (r_state != S_RUN)) begin
      r_table[prog_addr] <= prog_data;
    end
  end

  assign w_entry  = r_table[r_pc];
  assign w_wreg   = w_entry[C_WREG_LSB +: RW];
  assign w_onehot = {{(NREG-1){1'b0}}, 1'b1} << w_wreg;

  // Final entry of a pass: explicit last flag or the top table slot.
  assign w_retire_last = (r_state == S_RUN) && !hold &&
                         (w_entry[C_LAST_BIT] || (r_pc == PCW'(DEPTH-1)));

`ifdef ALU_SEQ_LOOP_EN
  logic [7:0] r_loop_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loop_rem <= 8'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_loop_rem <= loop_cnt;
    end else if (w_rewind) begin
      r_loop_rem <= r_loop_rem - 8'd1;
    end
  end

  assign w_rewind = w_retire_last && (r_loop_rem != 8'd0);
`else
  assign w_rewind = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
        end
      end
      S_RUN: begin
        if (!hold) begin
          if (w_retire_last) begin
            if (w_rewind) begin
              w_pc_nxt = '0;
            end else begin
              // pc stays on the final entry through DONE/IDLE.
              w_state_nxt = S_DONE;
            end
          end else begin
            w_pc_nxt = r_pc + PCW'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath controls: live only in RUN; hold suppresses the write strobes
  // but keeps the operand fields presented.
  always_comb begin
    reg_we = '0;
    FlagEn = 1'b0;
    RorI   = 1'b0;
    opcode = '0;
    Rsrc   = '0;
    Rdest  = '0;
    imm    = '0;
    if (r_state == S_RUN) begin
      RorI   = w_entry[C_RORI_BIT];
      opcode = w_entry[C_OP_LSB +: OPW];
      Rsrc   = w_entry[C_RSRC_LSB +: RW];
      Rdest  = w_entry[C_RDEST_LSB +: RW];
      imm    = w_entry[IMMW-1:0];
      if (!hold) begin
        reg_we = w_entry[C_WREN_BIT] ? w_onehot : '0;
        FlagEn = w_entry[C_FLAG_BIT];
      end
    end
  end

  assign pc   = r_pc;
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/alu_prog_sequencer.md
# alu_prog_sequencer

Programmable, parametrised successor to the fixed-sequence CPU datapath test FSMs. It holds a loadable program table of datapath control words. On `start` it replays the table one entry per clock, driving the register-file write enables, ALU opcode, source/destination selects, immediate, `RorI` and `FlagEn`. It sits where the hard-coded test FSMs sat, between the bench or boot loader and the register file / ALU datapath, and adds a hold (stall) input, busy/done status and an optional repeat count.

## Interface
Parameters:
- `DEPTH`, 16: number of program entries (power of two, ≥2); `PCW = $clog2(DEPTH)`.
- `NREG`, 16: register count (power of two); `RW = $clog2(NREG)`.
- `OPW`, 8: opcode width.
- `IMMW`, 8: immediate width.
- Derived: `ENTRY_W = 4 + OPW + 3*RW + IMMW` (32 with defaults).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `prog_we`  in  1  program-table write strobe.
- `prog_addr`  in  PCW  write address.
- `prog_data`  in  ENTRY_W  entry, MSB→LSB: `last`, `wr_en`, `wreg[RW]`, `flag_en`, `rori`, `opcode[OPW]`, `rsrc[RW]`, `rdest[RW]`, `imm[IMMW]`.
- `start`  in  1  begin a run, sampled in IDLE.
- `hold`  in  1  stall the current entry.
- `reg_we`  out  NREG  one-hot register write enable.
- `FlagEn`  out  1  flag register update enable.
- `RorI`  out  1  1 = immediate operand.
- `opcode`  out  OPW  ALU opcode.
- `Rsrc`, `Rdest`  out  RW  operand selects.
- `imm`  out  IMMW  immediate.
- `pc`  out  PCW  current entry index.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the final entry.

## Operation
- Program table is DEPTH×ENTRY_W flops, written synchronously when `prog_we`=1 and state≠RUN. Writes during RUN are dropped. Table contents are not cleared by `rst`.
- States:
  - IDLE: `start`=1 → RUN, `pc`←0.
  - RUN → DONE after the edge that retires an entry with `last`=1, or the entry at `pc`=DEPTH-1 (implicit last).
  - DONE → IDLE unconditionally after one cycle.
- In RUN, outputs decode `table[pc]` combinationally:
  - `reg_we = wr_en ? (1<<wreg) : 0`.
  - `FlagEn = flag_en`.
  - Other fields pass through.
- In IDLE/DONE all control outputs are 0 and `pc` holds its value.
- Each RUN clock with `hold`=0 retires the entry and `pc` increments. With `hold`=1, `pc` freezes, `reg_we` and `FlagEn` are forced to 0, and opcode/Rsrc/Rdest/imm/RorI stay presented.
- `start` during RUN or DONE is ignored; no restart mid-run.
- Reset mid-run: immediately IDLE, `pc`=0, all outputs 0, `done`=0.

## Timing
- Reset values: state IDLE, `pc`=0, `busy`=0, `done`=0, `reg_we`=0, `FlagEn`=0, `RorI`=0, `opcode`=0, `Rsrc`=0, `Rdest`=0, `imm`=0.
- `start` high at edge k → entry 0 visible in cycle k..k+1, entry n in cycle k+n (no holds).
- `busy`=1 exactly while in RUN; `done`=1 in the cycle after the last entry retires.
- A program of N entries with H hold cycles occupies N+H RUN cycles. Back-to-back run: `start` held high in DONE is ignored; the next sample is in IDLE, so the restart gap is 2 cycles.
- A table write at edge e is visible to a run starting at edge e+1 or later.

## Configuration
- `ALU_SEQ_LOOP_EN` defined:
  - Adds input `loop_cnt` [7:0], sampled at `start`.
  - On retiring the last entry with remaining count >0, the count decrements, `pc`←0 and the FSM stays in RUN. Total passes = `loop_cnt`+1.
  - `done` pulses only after the final pass.
  - Reset clears the count.
- Not defined: port absent; single pass per `start`.

## Test plan
- Reset mid-run: assert `rst` async at `pc`=3 → all outputs 0 same cycle, `busy`=0. After release, the table is intact and rerunning gives identical outputs.
- Load entries 0:{wr_en,wreg=2,flag_en,rori,opcode=0x0D,imm=20}, 1:{wr_en,wreg=1,opcode=0x0D,Rsrc=2,Rdest=1}, 2:{last,wr_en,wreg=3,flag_en,opcode=0x0E,Rsrc=2,Rdest=1}; pulse `start` → `reg_we`=0x0004, 0x0002, 0x0008 on consecutive cycles, `FlagEn`=1,0,1, then `done` pulse, `busy` low.
- Same program with `hold`=1 for 2 cycles at `pc`=1 → `reg_we`=0 and `FlagEn`=0 during hold, opcode stays 0x0D, total RUN length 5 cycles.
- No `last` set in a full DEPTH=16 table → 16 RUN cycles, `pc` 0→15, `done` after `pc`=15, no wrap.
- `prog_we` to address 0 and `start` pulses during RUN → table unchanged and run unaffected; a write after `done` takes effect on the next run.
- `ALU_SEQ_LOOP_EN`, `loop_cnt`=2, 3-entry program → 9 RUN cycles, `pc` sequence 0,1,2 ×3, single `done` pulse.
